// File: rtl/regbus_master.sv
// Register-bus master: accepts one write / read / read-modify-write command
// at a time, runs it on a simple strobed register bus and returns a response.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// RD    | read strobe on the bus, waiting for data_valid or timeout
// WR    | single-cycle write strobe on the bus
// RSP   | response held on rsp_* until rsp_ready
module regbus_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_WIDTH-1:0] cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  chip_select,
    output logic                  write_en,
    output logic                  read_en,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  data_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_RMW = 2'b10;
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_cmd_ready;
    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [7:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic                  r_cs;
    logic                  r_we;
    logic                  r_re;
    logic [DATA_WIDTH-1:0] r_bus_wdata;

    logic                  w_accept;
    logic [7:0]            w_cnt_inc;
    logic                  w_timeout;
    logic                  w_bus_nxt;
    logic [DATA_WIDTH-1:0] w_merge;

    assign w_accept  = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;
    assign w_cnt_inc = r_cnt + 8'd1;
    // data_valid wins over a timeout landing in the same cycle
    assign w_timeout = !data_valid && (w_cnt_inc == TO_CNT);
    assign w_bus_nxt = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
    // merge uses the live read_data: WR is only entered from RD in the capture cycle
    assign w_merge   = (read_data & ~r_mask) | (r_wdata & r_mask);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_WR:   w_state_nxt = S_WR;
                        OP_RD:   w_state_nxt = S_RD;
                        OP_RMW:  w_state_nxt = S_RD;
                        default: w_state_nxt = S_RSP;
                    endcase
                end
            end
            S_RD: begin
                if (data_valid)     w_state_nxt = (r_op == OP_RMW) ? S_WR : S_RSP;
                else if (w_timeout) w_state_nxt = S_RSP;
            end
            S_WR:    w_state_nxt = S_RSP;
            default: if (rsp_ready) w_state_nxt = S_IDLE;
        endcase
    end

    // Command latch, timeout counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else if (w_accept) begin
            r_op        <= cmd_op;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_mask      <= cmd_mask;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_error <= (cmd_op == 2'b11);
        end else if (r_state == S_RD) begin
            if (data_valid) begin
                r_rsp_rdata <= read_data;
                r_rsp_error <= 1'b0;
            end else begin
                r_cnt <= w_cnt_inc;
                if (w_timeout) begin
                    r_rsp_rdata <= '0;
                    r_rsp_error <= 1'b1;
                end
            end
        end
    end

    // Registered bus outputs and handshake, all decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready <= 1'b0;
            r_bus_addr  <= '0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_bus_wdata <= '0;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_cs        <= w_bus_nxt;
            r_re        <= (w_state_nxt == S_RD);
            r_we        <= (w_state_nxt == S_WR);
            r_bus_addr  <= w_bus_nxt ? ((r_state == S_IDLE) ? cmd_addr : r_addr) : '0;
            r_bus_wdata <= (w_state_nxt == S_WR) ?
                           ((r_state == S_IDLE) ? cmd_wdata : w_merge) : '0;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = (r_state == S_RSP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign addr        = r_bus_addr;
    assign chip_select = r_cs;
    assign write_en    = r_we;
    assign read_en     = r_re;
    assign write_data  = r_bus_wdata;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_regbus_master.sv
// Directed bench for regbus_master with hand-computed expectations.
module tb_regbus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] cmd_mask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [7:0]  addr;
    logic        chip_select;
    logic        write_en;
    logic        read_en;
    logic [31:0] write_data;
    logic [31:0] read_data = '0;
    logic        data_valid = 1'b0;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regbus_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(15)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .addr(addr), .chip_select(chip_select),
        .write_en(write_en), .read_en(read_en), .write_data(write_data),
        .read_data(read_data), .data_valid(data_valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one command at a negedge; it is accepted on the next posedge.
    task automatic send(input logic [1:0] op, input logic [7:0] a,
                        input logic [31:0] wd, input logic [31:0] m);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m;
        rsp_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Run a command to completion, observing the bus once per cycle.
    // dv_at: RD cycle (1-based) in which data_valid is raised, 0 = never.
    // hold : number of RSP cycles with rsp_ready held low.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] a,
                           input logic [31:0] wd, input logic [31:0] m,
                           input logic [31:0] rd, input int dv_at, input int hold,
                           output int n_re, output int n_we, output int n_busy,
                           output logic [31:0] wd_seen, output logic [31:0] rdata,
                           output logic err, output int n_rsp);
        logic bad_bus;
        logic bad_hold;
        logic done;
        n_re = 0; n_we = 0; n_busy = 0; n_rsp = 0;
        wd_seen = '0; rdata = '0; err = 1'b0;
        bad_bus = 1'b0; bad_hold = 1'b0; done = 1'b0;
        read_data = rd;
        send(op, a, wd, m);
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            n_busy++;
            if (read_en && write_en) bad_bus = 1'b1;
            if (chip_select !== (read_en | write_en)) bad_bus = 1'b1;
            if (chip_select && addr !== a) bad_bus = 1'b1;
            if (!chip_select && addr !== 8'h00) bad_bus = 1'b1;
            if (!write_en && write_data !== 32'h0) bad_bus = 1'b1;
            if (read_en) n_re++;
            if (write_en) begin
                n_we++;
                wd_seen = write_data;
            end
            if (rsp_valid) begin
                n_rsp++;
                if (n_rsp == 1) begin
                    rdata = rsp_rdata;
                    err   = rsp_error;
                end else if (rsp_rdata !== rdata || rsp_error !== err) begin
                    bad_hold = 1'b1;
                end
                if (cmd_ready) bad_hold = 1'b1;
            end
            data_valid = read_en && (dv_at != 0) && (n_re >= dv_at);
            rsp_ready  = rsp_valid && (n_rsp > hold);
            @(negedge clk);
        end
        data_valid = 1'b0;
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_bus_rules"}, bad_bus, 1'b0);
        chk({name, "_rsp_stable"}, bad_hold, 1'b0);
        chk({name, "_idle_ready"}, cmd_ready, 1'b1);
    endtask

    int          n_re, n_we, n_busy, n_rsp;
    logic [31:0] wd_seen, rdata;
    logic        err;

    initial begin
        // Reset state
        #12;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_outputs", {rsp_valid, rsp_error, chip_select, write_en, read_en, busy}, 6'b0);
        chk("rst_buses", {addr, write_data, rsp_rdata}, 72'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        // Write: WR, RSP busy -> 2 busy cycles (3 with the accept cycle)
        run_cmd("wr", 2'b00, 8'h00, 32'h5, 32'h0, 32'h0, 0, 0,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("wr_we_cycles", n_we, 1);
        chk("wr_re_cycles", n_re, 0);
        chk("wr_wdata", wd_seen, 32'h5);
        chk("wr_rsp", {err, rdata}, 33'h0);
        chk("wr_latency", n_busy, 2);

        // Read with data in first RD cycle
        run_cmd("rd", 2'b01, 8'h14, 32'h0, 32'h0, 32'h55AA, 1, 0,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("rd_re_cycles", n_re, 1);
        chk("rd_we_cycles", n_we, 0);
        chk("rd_rsp", {err, rdata}, {1'b0, 32'h55AA});
        chk("rd_latency", n_busy, 2);

        // RMW: (F0 & ~FF) | (0F & FF) = 0F
        run_cmd("rmw", 2'b10, 8'h30, 32'h0F, 32'hFF, 32'h000000F0, 1, 0,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("rmw_we_cycles", n_we, 1);
        chk("rmw_wdata", wd_seen, 32'h0000000F);
        chk("rmw_rsp", {err, rdata}, {1'b0, 32'hF0});
        chk("rmw_latency", n_busy, 3);

        // RMW with partial mask: (A5A5A5A5 & ~0000FF00) | (12345678 & 0000FF00)
        run_cmd("rmw2", 2'b10, 8'h31, 32'h12345678, 32'h0000FF00, 32'hA5A5A5A5, 2, 0,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("rmw2_wdata", wd_seen, 32'hA5A556A5);
        chk("rmw2_rsp", {err, rdata}, {1'b0, 32'hA5A5A5A5});

        // Timeout on RMW: 15 RD cycles, no write, error response
        run_cmd("to", 2'b10, 8'h40, 32'h1, 32'hFFFFFFFF, 32'hDEAD, 0, 0,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("to_re_cycles", n_re, 15);
        chk("to_we_cycles", n_we, 0);
        chk("to_rsp", {err, rdata}, {1'b1, 32'h0});

        // data_valid in the cycle the count would reach TIMEOUT is a success
        run_cmd("to_edge", 2'b01, 8'h41, 32'h0, 32'h0, 32'hCAFE, 15, 0,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("to_edge_re_cycles", n_re, 15);
        chk("to_edge_rsp", {err, rdata}, {1'b0, 32'hCAFE});

        // Backpressure: rsp_ready low for 5 RSP cycles
        run_cmd("bp", 2'b01, 8'h20, 32'h0, 32'h0, 32'h1234, 1, 5,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("bp_rsp_cycles", n_rsp, 6);
        chk("bp_rsp", {err, rdata}, {1'b0, 32'h1234});

        // Reserved opcode: straight to an error response, no strobes
        run_cmd("rsv", 2'b11, 8'h55, 32'hFFFF, 32'hFFFF, 32'h0, 0, 0,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("rsv_strobes", {n_re[7:0], n_we[7:0]}, 16'h0);
        chk("rsv_rsp", {err, rdata}, {1'b1, 32'h0});
        chk("rsv_latency", n_busy, 1);

        // Plain write with a wide pattern
        run_cmd("wr2", 2'b00, 8'hA5, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0,
                n_re, n_we, n_busy, wd_seen, rdata, err, n_rsp);
        chk("wr2_wdata", wd_seen, 32'hDEADBEEF);

        // Reset mid-RD: strobes drop without a clock edge, no response
        read_data = 32'h0;
        send(2'b01, 8'h66, 32'h0, 32'h0);
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rd_read_en", read_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rd_async_drop", {chip_select, read_en, addr}, 10'h0);
        chk("mid_rd_async_state", {busy, rsp_valid, cmd_ready}, 3'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rd_release", {cmd_ready, rsp_valid, busy}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regbus_master.md
REGBUS_MASTER -- requirements
Module: regbus_master

Interface
- REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
  - ADDR_WIDTH, 8, bus address width.
  - DATA_WIDTH, 32, bus data width.
  - TIMEOUT, 15, maximum number of RD cycles to wait for data_valid; legal range 1..255.
- REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  - clk, in, 1, single clock; all logic on the rising edge.
  - rst_n, in, 1, asynchronous active-low reset.
  - cmd_valid, in, 1, command request.
  - cmd_ready, out, 1, command accepted when high together with cmd_valid.
  - cmd_op, in, 2, operation: 00 write, 01 read, 10 read-modify-write, 11 reserved.
  - cmd_addr, in, ADDR_WIDTH, target register address.
  - cmd_wdata, in, DATA_WIDTH, write data.
  - cmd_mask, in, DATA_WIDTH, RMW bit mask (1 = replace bit).
  - rsp_valid, out, 1, response available.
  - rsp_ready, in, 1, response consumed when high together with rsp_valid.
  - rsp_rdata, out, DATA_WIDTH, read data returned.
  - rsp_error, out, 1, timeout or reserved opcode.
  - addr, out, ADDR_WIDTH, bus address.
  - chip_select, out, 1, bus select.
  - write_en, out, 1, bus write strobe.
  - read_en, out, 1, bus read strobe.
  - write_data, out, DATA_WIDTH, bus write data.
  - read_data, in, DATA_WIDTH, bus read data.
  - data_valid, in, 1, read data qualifier from the responder.
  - busy, out, 1, high in any state other than IDLE.

Function
- REQ-003 The FSM SHALL have exactly four states: IDLE, RD, WR, RSP.
- REQ-004 cmd_ready SHALL be 1 in IDLE only; one command is in flight at a time.
- REQ-005 On acceptance, the block SHALL latch op, addr, wdata and mask, then move on the next edge as follows:
  - op 00 to WR.
  - op 01 or op 10 to RD.
  - op 11 to RSP with rsp_error=1 and rsp_rdata=0, with no bus activity.
- REQ-006 All bus outputs SHALL be registered and change only on clock edges.
- REQ-007 In RD, the block SHALL drive chip_select=1, read_en=1, write_en=0 and addr=latched addr.
- REQ-008 In WR, the block SHALL drive chip_select=1, write_en=1, read_en=0, addr=latched addr and write_data=the write value.
- REQ-009 Outside RD and WR, chip_select, read_en, write_en, addr and write_data SHALL all be 0.
- REQ-010 read_en and write_en SHALL never be high in the same cycle.
- REQ-011 In RD, read_data SHALL be captured in any cycle where data_valid=1.
  - op 01: go to RSP with rsp_rdata=captured value and rsp_error=0.
  - op 10: go to WR.
- REQ-012 For op 10, the write value SHALL be (captured & ~mask) | (wdata & mask), and rsp_rdata SHALL return the pre-modify captured value.
- REQ-013 The timeout counter SHALL clear on RD entry and increment once per RD cycle without data_valid. When it reaches TIMEOUT, the FSM SHALL go to RSP with rsp_error=1 and rsp_rdata=0.
  - For op 10, the write phase SHALL be skipped on timeout.
- REQ-014 data_valid arriving in the same cycle the count reaches TIMEOUT SHALL count as success, not timeout.
- REQ-015 WR SHALL last exactly one cycle, then go to RSP. For op 00, rsp_rdata=0 and rsp_error=0.
- REQ-016 In RSP, rsp_valid SHALL be 1 and rsp_rdata and rsp_error SHALL stay stable until rsp_ready=1, then the FSM SHALL return to IDLE on the next edge.
- REQ-017 data_valid SHALL be ignored outside RD.
- REQ-018 With an immediate responder and rsp_ready held at 1, command latency SHALL be:
  - write: 3 cycles from accept to the return to IDLE.
  - read: 3 cycles.
  - RMW: 4 cycles.

Reset
- REQ-019 While rst_n=0, the block SHALL force state=IDLE, the counter=0, and all latched registers=0, regardless of clk.
- REQ-020 While rst_n=0, every output SHALL be 0 except cmd_ready, which SHALL be 0 during reset and 1 in the first cycle after reset releases.
- REQ-021 Reset asserted mid-transaction SHALL abort it immediately: bus strobes drop asynchronously and no response is produced.

Verification
- REQ-022 The bench SHALL cover these directed scenarios:
  - Write: op 00, addr 0x00, wdata 0x5 -> one cycle with chip_select=1, write_en=1, addr 0x00, write_data 0x5; then rsp_valid with rsp_rdata 0, rsp_error 0.
  - Read: responder returns 0x55AA with data_valid in the first RD cycle, op 01, addr 0x14 -> rsp_rdata 0x55AA, rsp_error 0, read_en high for exactly 1 cycle.
  - RMW: register reads 0x000000F0, wdata 0x0F, mask 0xFF -> write_data 0x0000000F in the WR cycle; rsp_rdata 0xF0.
  - Timeout: data_valid tied 0, TIMEOUT=15 -> read_en high for 15 cycles, then rsp_error=1, rsp_rdata 0, no write_en for op 10.
  - Backpressure and reserved op: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and cmd_ready 0 throughout; op 11 -> rsp_error=1 with no strobes.
  - Reset mid-RD: rst_n pulsed low during RD -> chip_select and read_en go 0 at once, no rsp_valid, cmd_ready 1 after release.
